// File: rtl/mdu_core_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
// The master drives the request side; the slave returns busy/done and HI/LO.
interface mdu_core_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_core.sv
// MIPS-style HI/LO multiply/divide unit. It holds the result for a fixed latency
// per operation class, computes it combinationally from the captured operands, and commits on the last cycle.
module mdu_core #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_core_if.slave  bus
);

  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef enum logic [2:0] {
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_NOP6, OP_NOP7
  } op_e;

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  state_e           r_state;
  op_e              r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
  logic             r_busy, r_done;

  logic                 w_signed, w_is_mul, w_div0, w_neg_a, w_neg_b;
  logic [2*WIDTH-1:0]   w_ext_a, w_ext_b, w_prod;
  logic [WIDTH-1:0]     w_mag_a, w_mag_b, w_den, w_q_mag, w_r_mag, w_quot, w_rem;
  op_e                  w_req_op;

  assign w_req_op = op_e'(bus.op);
  assign w_signed = (r_op == OP_MULT) || (r_op == OP_DIV);
  assign w_is_mul = (r_op == OP_MULT) || (r_op == OP_MULTU);
  assign w_div0   = (r_b == '0);

  // Sign- or zero-extend so one 2*WIDTH multiplier serves both MULT and MULTU.
  assign w_ext_a = {{WIDTH{w_signed & r_a[WIDTH-1]}}, r_a};
  assign w_ext_b = {{WIDTH{w_signed & r_b[WIDTH-1]}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Divide magnitudes, then restore signs: quotient truncates toward zero and
  // the remainder follows the dividend. MIN/-1 wraps back to MIN with a remainder of 0.
  assign w_neg_a = w_signed & r_a[WIDTH-1];
  assign w_neg_b = w_signed & r_b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -r_a : r_a;
  assign w_mag_b = w_neg_b ? -r_b : r_b;
  assign w_den   = w_div0 ? {{(WIDTH-1){1'b0}}, 1'b1} : w_mag_b;
  assign w_q_mag = w_mag_a / w_den;
  assign w_r_mag = w_mag_a % w_den;
  assign w_quot  = (w_neg_a ^ w_neg_b) ? -w_q_mag : w_q_mag;
  assign w_rem   = w_neg_a ? -w_r_mag : w_r_mag;

  // NOTE: every register here, captured operands included, is cleared by reset so a
  // reset mid-operation leaves nothing behind that could later commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_MULT;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.cancel) begin
            case (w_req_op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_a     <= bus.a;
                r_b     <= bus.b;
                r_op    <= w_req_op;
                r_cnt   <= (w_req_op == OP_MULT || w_req_op == OP_MULTU)
                           ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                r_busy  <= 1'b1;
                r_state <= S_RUN;
              end
              OP_MTHI: r_hi <= bus.a;
              OP_MTLO: r_lo <= bus.a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (bus.cancel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == CW'(1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
            if (w_is_mul) begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end else if (!w_div0) begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
